// File: rtl/in_txn_ctrl.sv
`default_nettype none
// ============================================================================
// in_txn_ctrl : one USB IN transaction (IN token, DATA0, ACK/NAK) with retry
// Rev 1.0
// ============================================================================
module in_txn_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RX_LIMIT       = 1024,
  parameter int MAX_ATTEMPTS   = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        done,
  output logic        success,
  output logic        failure,
  output logic [63:0] data_out,
  output logic        send_IN,
  output logic        send_ACK,
  output logic        send_NAK,
  input  logic        sent,
  input  logic        rec_start,
  input  logic        rec_DATA0,
  input  logic        data_valid,
  input  logic [63:0] data_rec
);

  localparam int TIMER_MAX = (TIMEOUT_CYCLES > RX_LIMIT) ? TIMEOUT_CYCLES : RX_LIMIT;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int ATT_W     = $clog2(MAX_ATTEMPTS + 1);

  localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] RX_VAL      = TIMER_W'(RX_LIMIT);
  localparam logic [ATT_W-1:0]   ATT_MAX     = ATT_W'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND_TOKEN = 3'd1,
    WAIT_RESP  = 3'd2,
    RECEIVING  = 3'd3,
    SEND_ACK   = 3'd4,
    SEND_NAK   = 3'd5,
    FINISH     = 3'd6
  } state_t;

  state_t             state_q,    state_d;
  logic [ATT_W-1:0]   attempt_q,  attempt_d;
  logic [TIMER_W-1:0] timer_q,    timer_d;
  logic [63:0]        data_q,     data_d;
  logic               ok_q,       ok_d;
  logic               send_in_q,  send_in_d;
  logic               send_ack_q, send_ack_d;
  logic               send_nak_q, send_nak_d;
  logic               attempt_fail;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      attempt_q  <= '0;
      timer_q    <= '0;
      data_q     <= '0;
      ok_q       <= 1'b0;
      send_in_q  <= 1'b0;
      send_ack_q <= 1'b0;
      send_nak_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      attempt_q  <= attempt_d;
      timer_q    <= timer_d;
      data_q     <= data_d;
      ok_q       <= ok_d;
      send_in_q  <= send_in_d;
      send_ack_q <= send_ack_d;
      send_nak_q <= send_nak_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    attempt_d    = attempt_q;
    timer_d      = timer_q;
    data_d       = data_q;
    ok_d         = ok_q;
    send_in_d    = 1'b0;
    send_ack_d   = 1'b0;
    send_nak_d   = 1'b0;
    attempt_fail = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          attempt_d = ATT_W'(1);
          data_d    = '0;
          ok_d      = 1'b0;
          send_in_d = 1'b1;
          state_d   = SEND_TOKEN;
        end
      end
      SEND_TOKEN: begin
        if (sent) begin
          timer_d = '0;
          state_d = WAIT_RESP;
        end
      end
      // The timer reads 0 in the first waiting cycle; the cycle in which it
      // equals the limit is the last one in which a response is still taken.
      WAIT_RESP: begin
        if (rec_start) begin
          timer_d = '0;
          state_d = RECEIVING;
        end else if (timer_q == TIMEOUT_VAL) begin
          attempt_fail = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      RECEIVING: begin
        if (rec_DATA0) begin
          if (data_valid) begin
            data_d     = data_rec;
            send_ack_d = 1'b1;
            state_d    = SEND_ACK;
          end else begin
            send_nak_d = 1'b1;
            state_d    = SEND_NAK;
          end
        end else if (timer_q == RX_VAL) begin
          attempt_fail = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      SEND_ACK: begin
        if (sent) begin
          ok_d    = 1'b1;
          state_d = FINISH;
        end
      end
      SEND_NAK: begin
        if (sent) begin
          attempt_fail = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (attempt_fail) begin
      if (attempt_q < ATT_MAX) begin
        attempt_d = attempt_q + ATT_W'(1);
        send_in_d = 1'b1;
        state_d   = SEND_TOKEN;
      end else begin
        ok_d    = 1'b0;
        state_d = FINISH;
      end
    end
  end

  assign done     = (state_q == FINISH);
  assign success  = done & ok_q;
  assign failure  = done & ~ok_q;
  assign data_out = data_q;
  assign send_IN  = send_in_q;
  assign send_ACK = send_ack_q;
  assign send_NAK = send_nak_q;

endmodule
`default_nettype wire

// File: tb/tb_in_txn_ctrl.sv
`default_nettype none
// ============================================================================
// tb_in_txn_ctrl : scoreboard bench for in_txn_ctrl
// Rev 1.0
// ============================================================================
module tb_in_txn_ctrl;

  localparam int TIMEOUT_CYCLES = 255;
  localparam int RX_LIMIT       = 1024;
  localparam int MAX_ATTEMPTS   = 8;

  logic        clock = 1'b0;
  logic        reset_n, start, sent, rec_start, rec_DATA0, data_valid;
  logic [63:0] data_rec;
  logic        done, success, failure, send_IN, send_ACK, send_NAK;
  logic [63:0] data_out;

  typedef struct packed {
    logic        ok;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   err = 0;
  int   chk = 0;
  int   sin_cnt = 0;

  in_txn_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .RX_LIMIT      (RX_LIMIT),
    .MAX_ATTEMPTS  (MAX_ATTEMPTS)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .done      (done),
    .success   (success),
    .failure   (failure),
    .data_out  (data_out),
    .send_IN   (send_IN),
    .send_ACK  (send_ACK),
    .send_NAK  (send_NAK),
    .sent      (sent),
    .rec_start (rec_start),
    .rec_DATA0 (rec_DATA0),
    .data_valid(data_valid),
    .data_rec  (data_rec)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: pops the scoreboard on every done and checks cycle-level rules.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (send_IN) sin_cnt = sin_cnt + 1;
      chk = chk + 1;
      if (!$onehot0({send_IN, send_ACK, send_NAK}) ||
          (!done && (success || failure)) || (done && (success == failure))) begin
        err = err + 1;
        $display("FAIL exclusivity: in=%b ack=%b nak=%b done=%b succ=%b fail=%b",
                 send_IN, send_ACK, send_NAK, done, success, failure);
      end
      if (done) begin
        chk = chk + 1;
        if (exp_q.size() == 0) begin
          err = err + 1;
          $display("FAIL unexpected_done: succ=%b fail=%b with no transaction pending",
                   success, failure);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (success !== e.ok || failure !== !e.ok || data_out !== e.data) begin
            err = err + 1;
            $display("FAIL done_result: succ=%b fail=%b data=%h, expected succ=%b fail=%b data=%h",
                     success, failure, data_out, e.ok, !e.ok, e.data);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk = chk + 1;
    if (act !== exp) begin
      err = err + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return send_IN;
      1:       return send_ACK;
      2:       return send_NAK;
      default: return done;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string name, output int n);
    n = 0;
    while (!pick(sel) && n < budget) begin
      cyc();
      n++;
    end
    if (!pick(sel)) begin
      chk = chk + 1;
      err = err + 1;
      $display("FAIL %s: no pulse within %0d cycles", name, budget);
    end
  endtask

  task automatic pulse_sent();
    sent = 1'b1; cyc(); sent = 1'b0;
  endtask

  task automatic pulse_rec_start();
    rec_start = 1'b1; cyc(); rec_start = 1'b0;
  endtask

  task automatic pulse_data(input logic valid, input logic [63:0] d);
    rec_DATA0 = 1'b1; data_valid = valid; data_rec = d;
    cyc();
    rec_DATA0 = 1'b0; data_valid = 1'b0; data_rec = '0;
  endtask

  task automatic do_start(input logic ok, input logic [63:0] d);
    int n;
    exp_q.push_back('{ok: ok, data: d});
    sin_cnt = 0;
    start = 1'b1; cyc(); start = 1'b0;
    wait_for(0, 2, "first_send_IN", n);
  endtask

  // From WAIT_RESP: answer with a good DATA0 and complete the handshake.
  task automatic finish_good(input logic [63:0] d);
    int n;
    pulse_rec_start();
    cyc();
    pulse_data(1'b1, d);
    wait_for(1, 2, "send_ACK", n);
    cyc();
    pulse_sent();
    wait_for(3, 3, "done_success", n);
    cyc();
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; sent = 1'b0; rec_start = 1'b0;
    rec_DATA0 = 1'b0; data_valid = 1'b0; data_rec = '0;
    repeat (3) cyc();
    check("reset_outputs", {57'd0, done, success, failure, send_IN, send_ACK, send_NAK, 1'b0}, 64'd0);
    check("reset_data_out", data_out, 64'd0);
    reset_n = 1'b1;
    cyc();

    // Clean read
    do_start(1'b1, 64'hDEAD_BEEF_0123_4567);
    repeat (3) cyc();
    pulse_sent();
    cyc();
    pulse_rec_start();
    cyc();
    pulse_data(1'b1, 64'hDEAD_BEEF_0123_4567);
    check("clean_send_ACK", {63'd0, send_ACK}, 64'd1);
    cyc();
    pulse_sent();
    wait_for(3, 3, "clean_done", n);
    cyc();
    check("clean_send_IN_count", sin_cnt, 1);
    check("clean_data_hold", data_out, 64'hDEAD_BEEF_0123_4567);

    // Corrupt then good
    do_start(1'b1, 64'h1122_3344_5566_7788);
    pulse_sent();
    pulse_rec_start();
    pulse_data(1'b0, 64'hFFFF_0000_FFFF_0000);
    wait_for(2, 2, "send_NAK", n);
    check("nak_data_out_unchanged", data_out, 64'd0);
    pulse_sent();
    wait_for(0, 2, "retry_send_IN", n);
    pulse_sent();
    finish_good(64'h1122_3344_5566_7788);
    check("corrupt_send_IN_count", sin_cnt, 2);

    // No response: every retry follows its sent by TIMEOUT_CYCLES+1 cycles
    do_start(1'b0, 64'd0);
    for (int i = 0; i < MAX_ATTEMPTS; i++) begin
      if (i > 0) begin
        wait_for(0, 300, "timeout_send_IN", n);
        check("timeout_spacing", n, TIMEOUT_CYCLES + 1);
      end
      pulse_sent();
    end
    wait_for(3, 300, "timeout_done", n);
    check("timeout_done_spacing", n, TIMEOUT_CYCLES + 1);
    cyc();
    check("timeout_send_IN_count", sin_cnt, MAX_ATTEMPTS);

    // Boundary: rec_start exactly at expiry is accepted
    do_start(1'b1, 64'hA5A5_5A5A_0F0F_F0F0);
    pulse_sent();
    repeat (TIMEOUT_CYCLES) cyc();
    pulse_rec_start();
    repeat (3) cyc();
    check("boundary_no_retry", {63'd0, send_IN}, 64'd0);
    pulse_data(1'b1, 64'hA5A5_5A5A_0F0F_F0F0);
    wait_for(1, 2, "boundary_send_ACK", n);
    pulse_sent();
    wait_for(3, 3, "boundary_done", n);
    cyc();
    check("boundary_send_IN_count", sin_cnt, 1);

    // Boundary: rec_start one cycle late loses to the retry
    do_start(1'b1, 64'h0000_0000_0000_0042);
    pulse_sent();
    repeat (TIMEOUT_CYCLES + 1) cyc();
    check("late_retry_send_IN", {63'd0, send_IN}, 64'd1);
    pulse_rec_start();
    pulse_sent();
    finish_good(64'h0000_0000_0000_0042);
    check("late_send_IN_count", sin_cnt, 2);

    // Busy start during WAIT_RESP must not restart the attempt count
    do_start(1'b0, 64'd0);
    for (int i = 0; i < MAX_ATTEMPTS; i++) begin
      if (i > 0) wait_for(0, 300, "busy_send_IN", n);
      pulse_sent();
      if (i == 2) begin
        repeat (9) cyc();
        start = 1'b1; cyc(); start = 1'b0;
      end
    end
    wait_for(3, 300, "busy_done", n);
    cyc();
    check("busy_send_IN_count", sin_cnt, MAX_ATTEMPTS);

    // Reset during RECEIVING aborts without a done pulse
    sin_cnt = 0;
    start = 1'b1; cyc(); start = 1'b0;
    pulse_sent();
    pulse_rec_start();
    cyc();
    reset_n = 1'b0;
    cyc();
    check("midreset_outputs", {58'd0, done, success, failure, send_IN, send_ACK, send_NAK}, 64'd0);
    check("midreset_data_out", data_out, 64'd0);
    reset_n = 1'b1;
    cyc();
    do_start(1'b1, 64'hCAFE_F00D_1234_ABCD);
    pulse_sent();
    finish_good(64'hCAFE_F00D_1234_ABCD);
    check("after_reset_send_IN_count", sin_cnt, 1);

    repeat (20) cyc();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
`default_nettype wire
